// File: rtl/kamacore_hazard_controller.sv
// Hazard sequencer for the five-stage kamacore pipeline: per-stage hold/flush
// generation, dmem request handshake, wait-state timeout and stall counter.
module kamacore_hazard_controller #(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
  input  logic                       id_uses_rs1,
  input  logic                       id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_destination_reg,
  input  logic                       ex_control_mem_read,
  input  logic                       ex_control_write_rd,
  input  logic                       ex_branch_taken,
  input  logic                       mem_access,
  input  logic                       dmem_ack,
  output logic                       dmem_req,
  output logic                       hold_if,
  output logic                       hold_id,
  output logic                       hold_ex,
  output logic                       hold_mem,
  output logic                       flush_id,
  output logic                       flush_ex,
  output logic                       flush_wb,
  output logic                       fault,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FAULT    = 2'd2;

  logic [1:0]                 r_state;
  logic [WAIT_W-1:0]          r_wait_cnt;
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;

  logic [1:0]        w_next_state;
  logic [WAIT_W-1:0] w_next_wait_cnt;
  logic              w_load_use;
  logic              w_dmem_req;
  logic              w_hold_front;
  logic              w_hold_back;
  logic              w_flush_id;
  logic              w_flush_ex;
  logic              w_flush_wb;
  logic              w_fault;

  // Load in EX whose result is needed by the instruction in ID
  always_comb begin
    w_load_use = ex_control_mem_read && ex_control_write_rd &&
                 (ex_destination_reg != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_destination_reg)) ||
                  (id_uses_rs2 && (id_rs2 == ex_destination_reg)));
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_dmem_req      = 1'b0;
    w_hold_front    = 1'b0;
    w_hold_back     = 1'b0;
    w_flush_id      = 1'b0;
    w_flush_ex      = 1'b0;
    w_flush_wb      = 1'b0;
    w_fault         = 1'b0;
    case (r_state)
      S_RUN: begin
        w_dmem_req = mem_access;
        if (mem_access && !dmem_ack) begin
          w_hold_front    = 1'b1;
          w_hold_back     = 1'b1;
          w_flush_wb      = 1'b1;
          w_next_state    = S_MEM_WAIT;
          w_next_wait_cnt = WAIT_W'(1);
        end else if (ex_branch_taken) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (w_load_use) begin
          w_hold_front = 1'b1;
          w_flush_ex   = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        w_dmem_req = 1'b1;
        // Ack takes precedence over the timeout compare in the same cycle
        if (dmem_ack) begin
          w_next_state    = S_RUN;
          w_next_wait_cnt = '0;
        end else begin
          w_hold_front = 1'b1;
          w_hold_back  = 1'b1;
          w_flush_wb   = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_next_state = S_FAULT;
          end else begin
            w_next_wait_cnt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      S_FAULT: begin
        w_hold_front = 1'b1;
        w_hold_back  = 1'b1;
        w_flush_wb   = 1'b1;
        w_fault      = 1'b1;
      end
      default: begin
        w_next_state    = S_RUN;
        w_next_wait_cnt = '0;
      end
    endcase
  end

  // All outputs are held low while reset is asserted
  always_comb begin
    dmem_req    = w_dmem_req   && !rst;
    hold_if     = w_hold_front && !rst;
    hold_id     = w_hold_front && !rst;
    hold_ex     = w_hold_back  && !rst;
    hold_mem    = w_hold_back  && !rst;
    flush_id    = w_flush_id   && !rst;
    flush_ex    = w_flush_ex   && !rst;
    flush_wb    = w_flush_wb   && !rst;
    fault       = w_fault      && !rst;
    stall_count = rst ? '0 : r_stall_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (hold_if && (r_stall_count != STALL_MAX)) begin
        r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_kamacore_hazard_controller.sv
// Directed bench for kamacore_hazard_controller: hand-computed control vectors
// per cycle, with a short timeout and a narrow stall counter to reach saturation.
module tb_kamacore_hazard_controller;

  localparam int unsigned RA = 5;
  localparam int unsigned SC = 4;

  // {dmem_req, hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, flush_wb, fault}
  localparam logic [8:0] E_NONE  = 9'b0_0000_0000;
  localparam logic [8:0] E_LU    = 9'b0_1100_0100;
  localparam logic [8:0] E_BR    = 9'b0_0000_1100;
  localparam logic [8:0] E_WAIT  = 9'b1_1111_0010;
  localparam logic [8:0] E_REQ   = 9'b1_0000_0000;
  localparam logic [8:0] E_FAULT = 9'b0_1111_0011;

  logic          clk = 1'b0;
  logic          rst;
  logic [RA-1:0] id_rs1, id_rs2, ex_destination_reg;
  logic          id_uses_rs1, id_uses_rs2;
  logic          ex_control_mem_read, ex_control_write_rd, ex_branch_taken;
  logic          mem_access, dmem_ack;
  logic          dmem_req, hold_if, hold_id, hold_ex, hold_mem;
  logic          flush_id, flush_ex, flush_wb, fault;
  logic [SC-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  kamacore_hazard_controller #(
    .REG_ADDR_WIDTH (RA),
    .TIMEOUT_CYCLES (4),
    .STALL_CNT_WIDTH(SC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_uses_rs1        (id_uses_rs1),
    .id_uses_rs2        (id_uses_rs2),
    .ex_destination_reg (ex_destination_reg),
    .ex_control_mem_read(ex_control_mem_read),
    .ex_control_write_rd(ex_control_write_rd),
    .ex_branch_taken    (ex_branch_taken),
    .mem_access         (mem_access),
    .dmem_ack           (dmem_ack),
    .dmem_req           (dmem_req),
    .hold_if            (hold_if),
    .hold_id            (hold_id),
    .hold_ex            (hold_ex),
    .hold_mem           (hold_mem),
    .flush_id           (flush_id),
    .flush_ex           (flush_ex),
    .flush_wb           (flush_wb),
    .fault              (fault),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_destination_reg = '0; ex_control_mem_read = 1'b0; ex_control_write_rd = 1'b0;
    ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  // Load x<rd> in EX; ID reads rs1/rs2 with the given use flags
  task automatic load_use(input logic [RA-1:0] rd, input logic [RA-1:0] rs1, input logic u1,
                          input logic [RA-1:0] rs2, input logic u2, input logic wr);
    idle();
    ex_destination_reg = rd; ex_control_mem_read = 1'b1; ex_control_write_rd = wr;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  // Sample the current cycle at negedge, then advance past the next rising edge
  task automatic cyc(input string tag, input logic [8:0] exp_ctl, input logic [SC-1:0] exp_cnt);
    @(negedge clk);
    check({tag, "_ctl"}, 32'({dmem_req, hold_if, hold_id, hold_ex, hold_mem,
                              flush_id, flush_ex, flush_wb, fault}), 32'(exp_ctl));
    check({tag, "_cnt"}, 32'(stall_count), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1);
    mem_access = 1'b1;
    cyc("rst0", E_NONE, 0);
    cyc("rst1", E_NONE, 0);
    rst = 1'b0;

    load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1); cyc("lu_rs1", E_LU, 0);
    idle();                                       cyc("lu_after", E_NONE, 1);
    load_use(5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1); cyc("lu_rs2", E_LU, 1);
    load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1); cyc("lu_unused", E_NONE, 2);
    load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1); cyc("lu_x0", E_NONE, 2);
    load_use(5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0); cyc("lu_nowr", E_NONE, 2);
    load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1);
    ex_branch_taken = 1'b1;                       cyc("br_lu", E_BR, 2);

    idle(); mem_access = 1'b1;
    cyc("w4_run", E_WAIT, 2);
    cyc("w4_mw1", E_WAIT, 3);
    cyc("w4_mw2", E_WAIT, 4);
    dmem_ack = 1'b1;                              cyc("w4_ack", E_REQ, 5);
    load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1); cyc("w4_inrun", E_LU, 5);
    idle();                                       cyc("w4_idle", E_NONE, 6);

    mem_access = 1'b1;
    cyc("aw_run", E_WAIT, 6);
    cyc("aw_mw1", E_WAIT, 7);
    cyc("aw_mw2", E_WAIT, 8);
    dmem_ack = 1'b1;                              cyc("aw_ack", E_REQ, 9);
    idle();                                       cyc("aw_idle", E_NONE, 9);

    mem_access = 1'b1;
    cyc("to_run", E_WAIT, 9);
    cyc("to_mw1", E_WAIT, 10);
    cyc("to_mw2", E_WAIT, 11);
    cyc("to_mw3", E_WAIT, 12);
    cyc("to_fault", E_FAULT, 13);
    dmem_ack = 1'b1;                              cyc("to_fack", E_FAULT, 14);
    cyc("to_sat", E_FAULT, 15);
    cyc("to_sat2", E_FAULT, 15);
    rst = 1'b1;                                   cyc("to_rst", E_NONE, 0);
    rst = 1'b0; idle();                           cyc("to_post", E_NONE, 0);

    mem_access = 1'b1;
    cyc("rw_run", E_WAIT, 0);
    cyc("rw_mw1", E_WAIT, 1);
    rst = 1'b1;                                   cyc("rw_rst", E_NONE, 0);
    rst = 1'b0; idle();                           cyc("rw_post", E_NONE, 0);
    mem_access = 1'b1; dmem_ack = 1'b1;           cyc("rw_run2", E_REQ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
